// File: rtl/oser10_link_ctrl.sv
// Link controller for a 10:1 output serializer: sequences serializer reset and
// training after PLL lock, then streams source words with idle-word filling.
module oser10_link_ctrl #(
    parameter int          RST_CYC    = 16,
    parameter int          TRAIN_CYC  = 1024,
    parameter logic [9:0]  TRAIN_WORD = 10'h354,
    parameter logic [9:0]  IDLE_WORD  = 10'h0AB
) (
    input  logic        clk_par,
    input  logic        rst,
    input  logic        pll_lock,
    input  logic        retrain,
    input  logic        clr_cnt,
    input  logic        s_valid,
    input  logic [9:0]  s_data,
    output logic        s_ready,
    output logic        oser_rst,
    output logic [9:0]  d_out,
    output logic        link_up,
    output logic [15:0] underrun_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RST   = 2'd1;
    localparam logic [1:0] ST_TRAIN = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [7:0]  RST_LAST   = 8'(RST_CYC - 1);
    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [15:0] train_cnt_q, train_cnt_d;
    logic        oser_rst_q, oser_rst_d;
    logic [9:0]  d_out_q, d_out_d;
    logic [15:0] urun_q, urun_d;
    logic        xfer;

    assign s_ready      = (state_q == ST_RUN);
    assign link_up      = (state_q == ST_RUN);
    assign oser_rst     = oser_rst_q;
    assign d_out        = d_out_q;
    assign underrun_cnt = urun_q;
    assign xfer         = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        train_cnt_d = train_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pll_lock) begin
                    state_d   = ST_RST;
                    rst_cnt_d = '0;
                end
            end
            ST_RST: begin
                if (!pll_lock) begin
                    state_d = ST_IDLE;
                end else if (rst_cnt_q == RST_LAST) begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            ST_TRAIN: begin
                // Lock loss beats retrain, retrain beats the normal hand-off to RUN.
                if (!pll_lock) begin
                    state_d = ST_IDLE;
                end else if (retrain) begin
                    train_cnt_d = '0;
                end else if (train_cnt_q == TRAIN_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    train_cnt_d = train_cnt_q + 16'd1;
                end
            end
            default: begin
                if (!pll_lock) begin
                    state_d = ST_IDLE;
                end else if (retrain) begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = '0;
                end
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        oser_rst_d = (state_d == ST_IDLE) || (state_d == ST_RST);
        case (state_d)
            ST_TRAIN: d_out_d = TRAIN_WORD;
            ST_RUN:   d_out_d = xfer ? s_data : IDLE_WORD;
            default:  d_out_d = 10'h000;
        endcase
        urun_d = urun_q;
        if (clr_cnt)
            urun_d = '0;
        else if ((state_q == ST_RUN) && !s_valid && (urun_q != 16'hFFFF))
            urun_d = urun_q + 16'd1;
    end

    always_ff @(posedge clk_par) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            train_cnt_q <= '0;
            oser_rst_q  <= 1'b1;
            d_out_q     <= 10'h000;
            urun_q      <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            train_cnt_q <= train_cnt_d;
            oser_rst_q  <= oser_rst_d;
            d_out_q     <= d_out_d;
            urun_q      <= urun_d;
        end
    end

endmodule

// File: tb/tb_oser10_link_ctrl.sv
// Bench for oser10_link_ctrl: fixed vector table, corner sequences, and random
// traffic checked against a position-based model of the link bring-up.
module tb_oser10_link_ctrl;

    localparam int R = 4;
    localparam int T = 8;

    logic        clk_par = 1'b0;
    logic        rst = 1'b1, pll_lock = 1'b0, retrain = 1'b0, clr_cnt = 1'b0, s_valid = 1'b0;
    logic [9:0]  s_data = '0;
    logic        s_ready, oser_rst, link_up;
    logic [9:0]  d_out;
    logic [15:0] underrun_cnt;

    always #5 clk_par = ~clk_par;

    oser10_link_ctrl #(.RST_CYC(R), .TRAIN_CYC(T)) dut (
        .clk_par(clk_par), .rst(rst), .pll_lock(pll_lock), .retrain(retrain),
        .clr_cnt(clr_cnt), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .oser_rst(oser_rst), .d_out(d_out), .link_up(link_up), .underrun_cnt(underrun_cnt)
    );

    int nvec = 0;
    int nmis = 0;

    // Model: m_pos counts cycles since lock; its range says which phase we are in.
    bit         m_on = 0;
    int         m_pos = 0;
    int         m_cnt = 0;
    logic [9:0] m_dout = '0;

    function automatic bit m_run();
        return m_on && (m_pos >= R + T);
    endfunction

    function automatic bit m_serrst();
        return !(m_on && (m_pos >= R));
    endfunction

    task automatic model_step();
        bit run;
        run = m_run();
        if (rst) begin
            m_on = 0; m_pos = 0; m_cnt = 0; m_dout = '0;
        end else begin
            if (clr_cnt) m_cnt = 0;
            else if (run && !s_valid && m_cnt < 65535) m_cnt++;
            if (!m_on) begin
                if (pll_lock) begin m_on = 1; m_pos = 0; end
            end else if (!pll_lock) m_on = 0;
            else if (retrain && m_pos >= R) m_pos = R;
            else if (m_pos < R + T) m_pos++;
            if (!m_on || m_pos < R) m_dout = 10'h000;
            else if (m_pos < R + T) m_dout = 10'h354;
            else m_dout = (run && s_valid) ? s_data : 10'h0AB;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, l, rt, c, v, input logic [9:0] d);
        rst = r; pll_lock = l; retrain = rt; clr_cnt = c; s_valid = v; s_data = d;
        @(posedge clk_par);
        model_step();
        #1;
    endtask

    task automatic chk_model();
        chk("d_out", {6'd0, d_out}, {6'd0, m_dout});
        chk("underrun_cnt", underrun_cnt, 16'(m_cnt));
        chk("link_up", {15'd0, link_up}, {15'd0, m_run()});
        chk("s_ready", {15'd0, s_ready}, {15'd0, m_run()});
        chk("oser_rst", {15'd0, oser_rst}, {15'd0, m_serrst()});
    endtask

    typedef struct {
        logic r, l, rt, c, v;
        logic [9:0]  d;
        logic [9:0]  dout;
        logic        link, oser;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(logic r, l, rt, c, v, logic [9:0] d,
                                logic [9:0] dout, logic link, oser, logic [15:0] cnt);
        vec_t x;
        x.r = r; x.l = l; x.rt = rt; x.c = c; x.v = v; x.d = d;
        x.dout = dout; x.link = link; x.oser = oser; x.cnt = cnt;
        return x;
    endfunction

    vec_t tbl[22];

    initial begin
        int ntrain;
        int k;
        // Bring-up with R=4/T=8, two data words, three underruns, clear, lock drop.
        tbl[0] = mk(1, 0, 0, 0, 0, 10'h000, 10'h000, 0, 1, 16'd0);
        tbl[1] = mk(0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 1, 16'd0);
        for (int i = 2; i < 6; i++)  tbl[i] = mk(0, 1, 0, 0, 0, 10'h000, 10'h000, 0, 1, 16'd0);
        for (int i = 6; i < 14; i++) tbl[i] = mk(0, 1, 0, 0, 0, 10'h000, 10'h354, 0, 0, 16'd0);
        tbl[14] = mk(0, 1, 0, 0, 0, 10'h000, 10'h0AB, 1, 0, 16'd0);
        tbl[15] = mk(0, 1, 0, 0, 1, 10'h2F1, 10'h2F1, 1, 0, 16'd0);
        tbl[16] = mk(0, 1, 0, 0, 1, 10'h10E, 10'h10E, 1, 0, 16'd0);
        tbl[17] = mk(0, 1, 0, 0, 0, 10'h155, 10'h0AB, 1, 0, 16'd1);
        tbl[18] = mk(0, 1, 0, 0, 0, 10'h155, 10'h0AB, 1, 0, 16'd2);
        tbl[19] = mk(0, 1, 0, 0, 0, 10'h155, 10'h0AB, 1, 0, 16'd3);
        tbl[20] = mk(0, 1, 0, 1, 0, 10'h155, 10'h0AB, 1, 0, 16'd0);
        tbl[21] = mk(0, 0, 1, 0, 1, 10'h3FF, 10'h000, 0, 1, 16'd0);

        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].r, tbl[i].l, tbl[i].rt, tbl[i].c, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d.d_out", i), {6'd0, d_out}, {6'd0, tbl[i].dout});
            chk($sformatf("tbl%0d.link_up", i), {15'd0, link_up}, {15'd0, tbl[i].link});
            chk($sformatf("tbl%0d.s_ready", i), {15'd0, s_ready}, {15'd0, tbl[i].link});
            chk($sformatf("tbl%0d.oser_rst", i), {15'd0, oser_rst}, {15'd0, tbl[i].oser});
            chk($sformatf("tbl%0d.cnt", i), underrun_cnt, tbl[i].cnt);
        end

        // Re-lock replays RST+TRAIN; retrain three cycles into TRAIN restarts it.
        for (int i = 0; i < R + 3; i++) begin
            cyc(0, 1, 0, 0, 0, 10'h000);
            chk_model();
        end
        cyc(0, 1, 1, 0, 0, 10'h000);
        chk_model();
        ntrain = (d_out == 10'h354) ? 1 : 0;
        k = 0;
        while (!link_up && k < 30) begin
            cyc(0, 1, 0, 0, 0, 10'h000);
            chk_model();
            if (d_out == 10'h354) ntrain++;
            k++;
        end
        chk("retrain_len", 16'(ntrain), 16'(T));
        chk("retrain_link", {15'd0, link_up}, 16'd1);

        // Reset mid-RUN with a word offered.
        cyc(0, 1, 0, 0, 0, 10'h000);
        cyc(0, 1, 0, 0, 0, 10'h000);
        cyc(1, 1, 0, 0, 1, 10'h3C3);
        chk("rst.d_out", {6'd0, d_out}, 16'h0000);
        chk("rst.link_up", {15'd0, link_up}, 16'd0);
        chk("rst.s_ready", {15'd0, s_ready}, 16'd0);
        chk("rst.oser_rst", {15'd0, oser_rst}, 16'd1);
        chk("rst.cnt", underrun_cnt, 16'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) != 0),
                ($urandom_range(0, 99) == 0), ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0), 10'($urandom));
            chk_model();
        end

        // Saturation: fresh bring-up, then a long underrun stretch.
        cyc(1, 0, 0, 0, 0, 10'h000);
        for (int i = 0; i < R + T + 1; i++) cyc(0, 1, 0, 0, 0, 10'h000);
        chk("sat.link_up", {15'd0, link_up}, 16'd1);
        for (int i = 0; i < 65540; i++) begin
            cyc(0, 1, 0, 0, 0, 10'h000);
            if (i >= 65530) chk_model();
        end
        chk("sat.cnt", underrun_cnt, 16'hFFFF);
        cyc(0, 1, 0, 0, 0, 10'h000);
        chk("sat.hold", underrun_cnt, 16'hFFFF);
        cyc(0, 1, 0, 1, 0, 10'h000);
        chk("sat.clr", underrun_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/oser10_link_ctrl.md
OSER10_LINK_CTRL -- requirements
Module: oser10_link_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYC, default 16: cycles the serializer reset is held after lock (range 1..255).
REQ-002 The block SHALL have parameter TRAIN_CYC, default 1024: cycles of training pattern before data (range 1..65535).
REQ-003 The block SHALL have parameter TRAIN_WORD, default 10'h354: 10-bit training symbol.
REQ-004 The block SHALL have parameter IDLE_WORD, default 10'h0AB: 10-bit filler symbol sent when no data is available.
REQ-005 The block SHALL have port clk_par, input, 1: parallel clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port pll_lock, input, 1: serial-clock PLL lock, already synchronous to clk_par.
REQ-008 The block SHALL have port retrain, input, 1: single-cycle request to replay the training sequence.
REQ-009 The block SHALL have port clr_cnt, input, 1: clears the underrun counter.
REQ-010 The block SHALL have port s_valid, input, 1: source word valid.
REQ-011 The block SHALL have port s_data, input, 10: source word; bit 0 is serialized first.
REQ-012 The block SHALL have port s_ready, output, 1: block accepts s_data this cycle.
REQ-013 The block SHALL have port oser_rst, output, 1: reset to the 10:1 serializer, active-high.
REQ-014 The block SHALL have port d_out, output, 10: word to the serializer parallel input.
REQ-015 The block SHALL have port link_up, output, 1: high while streaming data.
REQ-016 The block SHALL have port underrun_cnt, output, 16: count of RUN cycles with no transfer.

Function
REQ-017 The block SHALL implement FSM states IDLE, RST, TRAIN and RUN in a registered state variable.
REQ-018 The block SHALL transition IDLE->RST on the first cycle pll_lock=1.
REQ-019 The block SHALL stay in RST for exactly RST_CYC cycles, then transition to TRAIN.
REQ-020 The block SHALL stay in TRAIN for exactly TRAIN_CYC cycles, then transition to RUN.
REQ-021 pll_lock=0 in any non-IDLE state SHALL force IDLE on the next edge, with priority over every other transition.
REQ-022 retrain=1 in TRAIN or RUN (with pll_lock=1) SHALL force TRAIN on the next edge with the train counter restarted; retrain SHALL be ignored in IDLE and RST.
REQ-023 oser_rst SHALL be a register equal to 1 in IDLE and RST and 0 in TRAIN and RUN.
REQ-024 s_ready SHALL equal 1 exactly when state==RUN, with no combinational path from s_valid.
REQ-025 A transfer SHALL occur when s_valid&&s_ready; d_out SHALL equal that s_data on the following cycle (latency 1).
REQ-026 In RUN without a transfer, d_out SHALL equal IDLE_WORD next cycle, and underrun_cnt SHALL increment, saturating at 16'hFFFF.
REQ-027 d_out SHALL be TRAIN_WORD during every TRAIN cycle and 10'h000 during IDLE and RST, registered alongside the state.
REQ-028 link_up SHALL be 1 exactly when state==RUN.
REQ-029 clr_cnt=1 SHALL zero underrun_cnt next edge; simultaneous clr_cnt and underrun SHALL yield 0.
REQ-030 Counters SHALL be sized for the parameter maxima, and no counter SHALL wrap.
REQ-031 A word presented while the state is leaving RUN SHALL NOT be accepted, because s_ready is already 0 in the new state.

Reset
REQ-032 rst=1 SHALL set state=IDLE, oser_rst=1, d_out=10'h000, s_ready=0, link_up=0, underrun_cnt=0 and clear the RST/TRAIN counters on the next edge, overriding all inputs including mid-transfer.

Verification
REQ-033 rst, then pll_lock=1 with RST_CYC=4 and TRAIN_CYC=8 -> oser_rst high for 4 cycles after lock, d_out=10'h354 for 8 cycles, then link_up=1.
REQ-034 In RUN with s_valid=1 and s_data=10'h2F1,10'h10E -> d_out=10'h2F1,10'h10E on the next consecutive cycles, and underrun_cnt unchanged.
REQ-035 In RUN with s_valid=0 for 3 cycles -> d_out=10'h0AB for 3 cycles and underrun_cnt +3; a forced count of 16'hFFFF stays at FFFF.
REQ-036 pll_lock drop together with retrain in RUN -> IDLE next cycle, oser_rst=1, s_ready=0; on re-lock the full RST+TRAIN sequence replays.
REQ-037 retrain pulse mid-TRAIN -> the full TRAIN_CYC count restarts; clr_cnt coinciding with an underrun -> underrun_cnt=0.
REQ-038 rst asserted mid-RUN with s_valid=1 -> all outputs at their reset values on the next edge, and no word accepted.
